// File: rtl/ppt_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset defaults for the PPT register file.
package ppt_pkg;

    localparam logic [3:0] OFF_CLK_DIV  = 4'h0;
    localparam logic [3:0] OFF_PERIOD_L = 4'h1;
    localparam logic [3:0] OFF_PERIOD_H = 4'h2;
    localparam logic [3:0] OFF_WIDTH_L  = 4'h3;
    localparam logic [3:0] OFF_WIDTH_H  = 4'h4;
    localparam logic [3:0] OFF_COUNT_L  = 4'h5;
    localparam logic [3:0] OFF_COUNT_H  = 4'h6;
    localparam logic [3:0] OFF_CTRL     = 4'h7;
    localparam logic [3:0] OFF_CDONE_L  = 4'h8;
    localparam logic [3:0] OFF_CDONE_H  = 4'h9;
    localparam logic [3:0] OFF_STATUS   = 4'hA;
    localparam logic [3:0] OFF_IRQ_EN   = 4'hB;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_COMMIT_BIT = 1;
    localparam int STAT_DONE_BIT   = 0;
    localparam int STAT_BUSY_BIT   = 1;
    localparam int IRQ_EN_BIT      = 0;

    localparam logic [4:0]  RST_CLK_DIV = 5'd9;
    localparam logic [14:0] RST_PERIOD  = 15'd128;
    localparam logic [14:0] RST_WIDTH   = 15'd1;
    localparam int          RST_COUNT   = 16;

    typedef struct packed {
        logic [4:0]  clk_div;
        logic [14:0] period;
        logic [14:0] width;
    } ppt_tim_t;

    localparam ppt_tim_t RST_TIM = '{clk_div: RST_CLK_DIV, period: RST_PERIOD, width: RST_WIDTH};

endpackage

// File: rtl/ppt_chan_regs.sv
// Per-channel staging/active settings, RUN, sticky DONE, IRQ_EN and COUNT_DONE high-byte snapshot.
// Latency: every register updates on the clock edge of the write; no backpressure, writes always accepted.
module ppt_chan_regs
    import ppt_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter bit RUN_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_vld,
    input  logic [3:0]       wr_off,
    input  logic [7:0]       wr_dat,
    input  logic             snap_vld,
    input  logic [7:0]       cdone_hi,
    input  logic             done,
    output ppt_tim_t         stg_tim,
    output ppt_tim_t         act_tim,
    output logic [CNT_W-1:0] stg_count,
    output logic [CNT_W-1:0] act_count,
    output logic             run,
    output logic             done_flag,
    output logic             irq_en,
    output logic [7:0]       snap
);

    ppt_tim_t         stg_tim_q, stg_tim_d, act_tim_q, act_tim_d;
    logic [CNT_W-1:0] stg_count_q, stg_count_d, act_count_q, act_count_d;
    logic             run_q, run_d, done_flag_q, done_flag_d;
    logic             irq_en_q, irq_en_d, done_prev_q, done_prev_d;
    logic [7:0]       snap_q, snap_d;

    always_comb begin
        stg_tim_d   = stg_tim_q;
        act_tim_d   = act_tim_q;
        stg_count_d = stg_count_q;
        act_count_d = act_count_q;
        run_d       = run_q;
        done_flag_d = done_flag_q;
        irq_en_d    = irq_en_q;
        done_prev_d = done;
        snap_d      = snap_q;

        if (snap_vld) snap_d = cdone_hi;

        if (wr_vld) begin
            case (wr_off)
                OFF_CLK_DIV:  stg_tim_d.clk_div       = wr_dat[4:0];
                OFF_PERIOD_L: stg_tim_d.period[7:0]   = wr_dat;
                OFF_PERIOD_H: stg_tim_d.period[14:8]  = wr_dat[6:0];
                OFF_WIDTH_L:  stg_tim_d.width[7:0]    = wr_dat;
                OFF_WIDTH_H:  stg_tim_d.width[14:8]   = wr_dat[6:0];
                OFF_COUNT_L:  stg_count_d[7:0]        = wr_dat;
                OFF_COUNT_H: begin
                    // Loop bound makes this a no-op when CNT_W is 8.
                    for (int i = 8; i < CNT_W; i++) stg_count_d[i] = wr_dat[i-8];
                end
                OFF_CTRL: begin
                    run_d = wr_dat[CTRL_RUN_BIT];
                    if (wr_dat[CTRL_COMMIT_BIT]) begin
                        act_tim_d   = stg_tim_q;
                        act_count_d = stg_count_q;
                    end
                end
                OFF_STATUS:   if (wr_dat[STAT_DONE_BIT]) done_flag_d = 1'b0;
                OFF_IRQ_EN:   irq_en_d = wr_dat[IRQ_EN_BIT];
                default: ;
            endcase
        end

        // A done rising edge wins over a same-cycle write-1-to-clear.
        if (done && !done_prev_q) done_flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_tim_q   <= RST_TIM;
            act_tim_q   <= RST_TIM;
            stg_count_q <= CNT_W'(RST_COUNT);
            act_count_q <= CNT_W'(RST_COUNT);
            run_q       <= RUN_RST;
            done_flag_q <= 1'b0;
            irq_en_q    <= 1'b0;
            done_prev_q <= 1'b0;
            snap_q      <= 8'h00;
        end else begin
            stg_tim_q   <= stg_tim_d;
            act_tim_q   <= act_tim_d;
            stg_count_q <= stg_count_d;
            act_count_q <= act_count_d;
            run_q       <= run_d;
            done_flag_q <= done_flag_d;
            irq_en_q    <= irq_en_d;
            done_prev_q <= done_prev_d;
            snap_q      <= snap_d;
        end
    end

    assign stg_tim   = stg_tim_q;
    assign act_tim   = act_tim_q;
    assign stg_count = stg_count_q;
    assign act_count = act_count_q;
    assign run       = run_q;
    assign done_flag = done_flag_q;
    assign irq_en    = irq_en_q;
    assign snap      = snap_q;

endmodule

// File: rtl/ppt_regfile.sv
// Byte-wide register file for NCH PPT channels: address decode, read mux and level irq.
// Latency: writes land on the next edge, reads are combinational; no backpressure.
module ppt_regfile
    import ppt_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           address,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic                 write_enable,
    input  logic                 read_enable,
    output logic [NCH*5-1:0]     clk_div,
    output logic [NCH*15-1:0]    period,
    output logic [NCH*15-1:0]    width,
    output logic [NCH*CNT_W-1:0] count,
    output logic [NCH-1:0]       run_ppt,
    input  logic [NCH*CNT_W-1:0] count_done,
    input  logic [NCH-1:0]       done,
    input  logic [NCH-1:0]       busy,
    output logic                 irq
);

    logic [3:0] ch_sel;
    logic [3:0] off_sel;
    assign ch_sel  = address[7:4];
    assign off_sel = address[3:0];

    ppt_tim_t         stg_tim   [NCH];
    ppt_tim_t         act_tim   [NCH];
    logic [CNT_W-1:0] stg_count [NCH];
    logic [CNT_W-1:0] act_count [NCH];
    logic [7:0]       snap      [NCH];
    logic [NCH-1:0]   done_flag;
    logic [NCH-1:0]   irq_en;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic       hit;
        logic [7:0] cdone_hi;
        assign hit      = (ch_sel == 4'(g));
        assign cdone_hi = 8'(count_done[g*CNT_W +: CNT_W] >> 8);

        ppt_chan_regs #(
            .CNT_W   (CNT_W),
            .RUN_RST (g == 0)
        ) u_regs (
            .clk       (clk),
            .rstn      (rstn),
            .wr_vld    (write_enable && hit),
            .wr_off    (off_sel),
            .wr_dat    (data_in),
            .snap_vld  (read_enable && !write_enable && hit && (off_sel == OFF_CDONE_L)),
            .cdone_hi  (cdone_hi),
            .done      (done[g]),
            .stg_tim   (stg_tim[g]),
            .act_tim   (act_tim[g]),
            .stg_count (stg_count[g]),
            .act_count (act_count[g]),
            .run       (run_ppt[g]),
            .done_flag (done_flag[g]),
            .irq_en    (irq_en[g]),
            .snap      (snap[g])
        );

        assign clk_div[g*5 +: 5]      = act_tim[g].clk_div;
        assign period[g*15 +: 15]     = act_tim[g].period;
        assign width[g*15 +: 15]      = act_tim[g].width;
        assign count[g*CNT_W +: CNT_W] = act_count[g];
    end

    // Bytes 0x0-0x6 read back staging, so software sees what the next commit will apply.
    always_comb begin
        data_out = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == 4'(i)) begin
                case (off_sel)
                    OFF_CLK_DIV:  data_out = {3'b000, stg_tim[i].clk_div};
                    OFF_PERIOD_L: data_out = stg_tim[i].period[7:0];
                    OFF_PERIOD_H: data_out = {1'b0, stg_tim[i].period[14:8]};
                    OFF_WIDTH_L:  data_out = stg_tim[i].width[7:0];
                    OFF_WIDTH_H:  data_out = {1'b0, stg_tim[i].width[14:8]};
                    OFF_COUNT_L:  data_out = stg_count[i][7:0];
                    OFF_COUNT_H:  data_out = 8'(stg_count[i] >> 8);
                    OFF_CTRL:     data_out[CTRL_RUN_BIT] = run_ppt[i];
                    OFF_CDONE_L:  data_out = count_done[i*CNT_W +: 8];
                    OFF_CDONE_H:  data_out = snap[i];
                    OFF_STATUS: begin
                        data_out[STAT_DONE_BIT] = done_flag[i];
                        data_out[STAT_BUSY_BIT] = busy[i];
                    end
                    OFF_IRQ_EN:   data_out[IRQ_EN_BIT] = irq_en[i];
                    default:      data_out = 8'h00;
                endcase
            end
        end
    end

    assign irq = |(done_flag & irq_en);

endmodule

// File: tb/tb_ppt_regfile.sv
// Randomized bench for ppt_regfile against a register-map-level model, plus directed literal checks.
module tb_ppt_regfile;

    localparam int NCH   = 2;
    localparam int CNT_W = 16;
    localparam int CMASK = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [7:0]           address = 8'h00;
    logic [7:0]           data_in = 8'h00;
    logic [7:0]           data_out;
    logic                 write_enable = 1'b0;
    logic                 read_enable = 1'b0;
    logic [NCH*5-1:0]     clk_div;
    logic [NCH*15-1:0]    period;
    logic [NCH*15-1:0]    width;
    logic [NCH*CNT_W-1:0] count;
    logic [NCH-1:0]       run_ppt;
    logic [NCH*CNT_W-1:0] count_done = '0;
    logic [NCH-1:0]       done = '0;
    logic [NCH-1:0]       busy = '0;
    logic                 irq;

    ppt_regfile #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .clk_div      (clk_div),
        .period       (period),
        .width        (width),
        .count        (count),
        .run_ppt      (run_ppt),
        .count_done   (count_done),
        .done         (done),
        .busy         (busy),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: plain integers per channel, straight from the register map.
    int m_scd[NCH], m_sper[NCH], m_swid[NCH], m_scnt[NCH];
    int m_acd[NCH], m_aper[NCH], m_awid[NCH], m_acnt[NCH];
    int m_run[NCH], m_done[NCH], m_ien[NCH], m_snap[NCH], m_prev[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_scd[c] = 9;   m_acd[c] = 9;
            m_sper[c] = 128; m_aper[c] = 128;
            m_swid[c] = 1;  m_awid[c] = 1;
            m_scnt[c] = 16; m_acnt[c] = 16;
            m_run[c] = (c == 0) ? 1 : 0;
            m_done[c] = 0; m_ien[c] = 0; m_snap[c] = 0; m_prev[c] = 0;
        end
    endtask

    function automatic int cd_of(input int c);
        return int'(count_done[c*CNT_W +: CNT_W]);
    endfunction

    function automatic int exp_rd(input logic [7:0] a);
        int c, off;
        c = int'(a[7:4]);
        off = int'(a[3:0]);
        if (c >= NCH) return 0;
        case (off)
            0:  return m_scd[c];
            1:  return m_sper[c] & 8'hff;
            2:  return m_sper[c] >> 8;
            3:  return m_swid[c] & 8'hff;
            4:  return m_swid[c] >> 8;
            5:  return m_scnt[c] & 8'hff;
            6:  return (m_scnt[c] >> 8) & 8'hff;
            7:  return m_run[c];
            8:  return cd_of(c) & 8'hff;
            9:  return m_snap[c];
            10: return (int'(busy[c]) << 1) | m_done[c];
            11: return m_ien[c];
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int c, off, d;
        bit rise[NCH];
        c = int'(address[7:4]);
        off = int'(address[3:0]);
        d = int'(data_in);
        for (int k = 0; k < NCH; k++) begin
            rise[k] = done[k] && (m_prev[k] == 0);
            m_prev[k] = int'(done[k]);
        end
        if (read_enable && !write_enable && off == 8 && c < NCH)
            m_snap[c] = (cd_of(c) >> 8) & 8'hff;
        if (write_enable && c < NCH) begin
            case (off)
                0:  m_scd[c] = d & 5'h1f;
                1:  m_sper[c] = (m_sper[c] & 16'h7f00) | d;
                2:  m_sper[c] = (m_sper[c] & 8'hff) | ((d & 8'h7f) << 8);
                3:  m_swid[c] = (m_swid[c] & 16'h7f00) | d;
                4:  m_swid[c] = (m_swid[c] & 8'hff) | ((d & 8'h7f) << 8);
                5:  m_scnt[c] = ((m_scnt[c] & ~8'hff) | d) & CMASK;
                6:  m_scnt[c] = ((m_scnt[c] & 8'hff) | (d << 8)) & CMASK;
                7: begin
                    m_run[c] = d & 1;
                    if (d & 2) begin
                        m_acd[c] = m_scd[c]; m_aper[c] = m_sper[c];
                        m_awid[c] = m_swid[c]; m_acnt[c] = m_scnt[c];
                    end
                end
                10: if (d & 1) m_done[c] = 0;
                11: m_ien[c] = d & 1;
                default: ;
            endcase
        end
        for (int k = 0; k < NCH; k++) if (rise[k]) m_done[k] = 1;
    endtask

    always @(posedge clk) if (rstn) model_step();

    // Single compare process: all outputs against the model, every cycle.
    always @(negedge clk) begin
        logic [NCH*5-1:0]     e_cd;
        logic [NCH*15-1:0]    e_per, e_wid;
        logic [NCH*CNT_W-1:0] e_cnt;
        logic [NCH-1:0]       e_run;
        logic                 e_irq;
        e_irq = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            e_cd[c*5 +: 5]          = 5'(m_acd[c]);
            e_per[c*15 +: 15]       = 15'(m_aper[c]);
            e_wid[c*15 +: 15]       = 15'(m_awid[c]);
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_acnt[c]);
            e_run[c]                = m_run[c][0];
            e_irq                   = e_irq | (m_done[c][0] & m_ien[c][0]);
        end
        chk("clk_div", 64'(clk_div), 64'(e_cd));
        chk("period", 64'(period), 64'(e_per));
        chk("width", 64'(width), 64'(e_wid));
        chk("count", 64'(count), 64'(e_cnt));
        chk("run_ppt", 64'(run_ppt), 64'(e_run));
        chk("irq", 64'(irq), 64'(e_irq));
        chk("data_out", 64'(data_out), 64'(exp_rd(address)));
    end

    task automatic bus(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_in      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        write_enable = 1'b0;
        read_enable  = 1'b1;
        address      = a;
        #1;
        chk(nm, 64'(data_out), 64'(exp));
        @(posedge clk);
        #1;
        read_enable = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // Power-on defaults.
        chk("rst_clk_div0", 64'(clk_div[4:0]), 64'd9);
        chk("rst_period0", 64'(period[14:0]), 64'd128);
        chk("rst_width0", 64'(width[14:0]), 64'd1);
        chk("rst_count0", 64'(count[15:0]), 64'd16);
        chk("rst_run", 64'(run_ppt), 64'b01);
        chk("rst_irq", 64'(irq), 64'd0);

        // Staging then commit on channel 1.
        bus(1'b1, 1'b0, 8'h11, 8'h40);
        bus(1'b1, 1'b0, 8'h12, 8'h01);
        chk("period1_staged", 64'(period[15 +: 15]), 64'd128);
        bus(1'b1, 1'b0, 8'h17, 8'h02);
        chk("period1_commit", 64'(period[15 +: 15]), 64'h140);
        chk("run1_after_commit", 64'(run_ppt[1]), 64'd0);
        rd_chk("rd_period1_l", 8'h11, 8'h40);

        // COUNT_DONE snapshot.
        count_done[15:0] = 16'h1234;
        rd_chk("rd_cdone_l", 8'h08, 8'h34);
        count_done[15:0] = 16'h5678;
        rd_chk("rd_cdone_h", 8'h09, 8'h12);

        // DONE / irq with set-over-clear priority.
        bus(1'b1, 1'b0, 8'h0B, 8'h01);
        done[0] = 1'b1;
        bus(1'b0, 1'b0, 8'h00, 8'h00);
        chk("irq_set", 64'(irq), 64'd1);
        rd_chk("rd_status_set", 8'h0A, 8'h01);
        done[0] = 1'b0;
        bus(1'b0, 1'b0, 8'h00, 8'h00);
        done[0] = 1'b1;
        bus(1'b1, 1'b0, 8'h0A, 8'h01);
        chk("irq_set_wins", 64'(irq), 64'd1);
        rd_chk("rd_status_set_wins", 8'h0A, 8'h01);
        bus(1'b1, 1'b0, 8'h0A, 8'h01);
        chk("irq_cleared", 64'(irq), 64'd0);
        done[0] = 1'b0;

        // Out-of-range channel.
        bus(1'b1, 1'b0, 8'h25, 8'hAA);
        rd_chk("rd_bad_ch", 8'h25, 8'h00);

        // Reset asserted during a commit write.
        bus(1'b1, 1'b0, 8'h00, 8'h03);
        chk("clk_div0_staged_only", 64'(clk_div[4:0]), 64'd9);
        address = 8'h07; data_in = 8'h03; write_enable = 1'b1;
        #2 rstn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        write_enable = 1'b0;
        chk("rst_mid_clk_div0", 64'(clk_div[4:0]), 64'd9);
        chk("rst_mid_period1", 64'(period[15 +: 15]), 64'd128);
        chk("rst_mid_run", 64'(run_ppt), 64'b01);
        rd_chk("rst_mid_stg_clk_div0", 8'h00, 8'h09);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) done[c] = ~done[c];
                busy[c] = 1'($urandom);
                if ($urandom_range(0, 7) == 0) count_done[c*CNT_W +: CNT_W] = CNT_W'($urandom);
            end
            bus(1'($urandom), 1'($urandom),
                {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))}, 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
